ps2_key_decoder: RTL and testbench

Receives raw PS/2 keyboard frames, tracks make/break, extended-prefix and shift state, and translates key presses into the 8-bit character/command code consumed by `model_editor.ch_input`. Sits directly upstream of the editor, between the keyboard pins and the editor's input. Emits exactly one single-cycle non-zero code per accepted key press and holds zero otherwise, so the editor appends each key once.

---
 rtl/ps2_key_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and Set-2 scan-code translator feeding the editor's
// character input with single-cycle codes.
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ch_code,
    output logic       frame_err,
    output logic       shift_state
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          rx_err_q, rx_err_d;
    logic          brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
    logic [7:0]    ch_code_q, ch_code_d;
    logic          frame_err_q, frame_err_d;
    logic          fall_c;

    // Letter index 1..26 for a Set-2 make code, 0 when not a letter.
    function automatic logic [4:0] letter_idx(input logic [7:0] sc);
        logic [4:0] r;
        case (sc)
            8'h1C: r = 5'd1;   8'h32: r = 5'd2;   8'h21: r = 5'd3;   8'h23: r = 5'd4;
            8'h24: r = 5'd5;   8'h2B: r = 5'd6;   8'h34: r = 5'd7;   8'h33: r = 5'd8;
            8'h43: r = 5'd9;   8'h3B: r = 5'd10;  8'h42: r = 5'd11;  8'h4B: r = 5'd12;
            8'h3A: r = 5'd13;  8'h31: r = 5'd14;  8'h44: r = 5'd15;  8'h4D: r = 5'd16;
            8'h15: r = 5'd17;  8'h2D: r = 5'd18;  8'h1B: r = 5'd19;  8'h2C: r = 5'd20;
            8'h3C: r = 5'd21;  8'h2A: r = 5'd22;  8'h1D: r = 5'd23;  8'h22: r = 5'd24;
            8'h35: r = 5'd25;  8'h1A: r = 5'd26;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Editor code for a make code given prefix and shift state; 0 = unmapped.
    function automatic logic [7:0] xlate(input logic [7:0] sc, input logic ext, input logic shf);
        logic [7:0] r;
        logic [4:0] li;
        li = letter_idx(sc);
        r  = 8'd0;
        if (ext) begin
            if (sc == 8'h75)      r = 8'd67;
            else if (sc == 8'h72) r = 8'd68;
        end else if (li != 5'd0) begin
            r = shf ? 8'(li) + 8'd26 : 8'(li);
        end else begin
            case (sc)
                8'h25:   r = shf ? 8'd53 : 8'd0;
                8'h46:   r = shf ? 8'd54 : 8'd0;
                8'h45:   r = shf ? 8'd55 : 8'd0;
                8'h55:   r = shf ? 8'd0 : 8'd56;
                8'h5D:   r = 8'd58;
                8'h29:   r = 8'd59;
                8'h49:   r = shf ? 8'd0 : 8'd60;
                8'h66:   r = 8'd65;
                8'h5A:   r = 8'd66;
                default: r = 8'd0;
            endcase
        end
        return r;
    endfunction

    // Pin synchronizers and falling-edge detect on the synchronized clock.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        fall_c     = clk_prev_q & ~clk_s2_q;
    end

    // Frame receiver next state: start, 8 data bits LSB first, odd parity, stop, timeout abort.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_ok_d   = par_ok_q;
        tmo_cnt_d  = tmo_cnt_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        rx_err_d   = 1'b0;

        if (fall_c)                    tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (fall_c && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall_c) begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall_c) begin
                    par_ok_d = ^{dat_s2_q, shreg_q};
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_c) begin
                    state_d = S_IDLE;
                    if (par_ok_q && dat_s2_q) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shreg_q;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !fall_c && tmo_cnt_q == TMO_MAX) begin
            state_d  = S_IDLE;
            rx_err_d = 1'b1;
        end
        if (state_d == S_IDLE) tmo_cnt_d = '0;
    end

    // Byte interpreter: prefix/break/shift tracking and translation to editor codes.
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        shift_d     = shift_q;
        ch_code_d   = 8'd0;
        frame_err_d = rx_err_q;
        if (rx_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!ext_q && (byte_q == 8'h12 || byte_q == 8'h59)) shift_d = !brk_q;
                else if (!brk_q) ch_code_d = xlate(byte_q, ext_q, shift_q);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            par_ok_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= 8'd0;
            rx_err_q    <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            shift_q     <= 1'b0;
            ch_code_q   <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            tmo_cnt_q   <= tmo_cnt_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            rx_err_q    <= rx_err_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            shift_q     <= shift_d;
            ch_code_q   <= ch_code_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ch_code     = ch_code_q;
    assign frame_err   = frame_err_q;
    assign shift_state = shift_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios followed by random key streams,
// all checked against a scan-code reference model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int unsigned TMO = 300;
    localparam int H   = 16;
    localparam int GAP = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ch_code;
    logic       frame_err;
    logic       shift_state;

    ps2_key_decoder #(.TIMEOUT(TMO)) dut (
        .clk_25mhz   (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ch_code     (ch_code),
        .frame_err   (frame_err),
        .shift_state (shift_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observed output stream
    logic [7:0] got_q[$];
    int         err_seen = 0;
    int         dbl = 0;
    time        code_t = 0;
    time        stop_t = 0;
    logic [7:0] prev_code = 8'd0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (ch_code !== 8'd0) begin
            got_q.push_back(ch_code);
            code_t = $time;
            if (prev_code !== 8'd0) dbl++;
        end
        if (frame_err === 1'b1) begin
            err_seen++;
            if (prev_err === 1'b1) dbl++;
        end
        prev_code = ch_code;
        prev_err  = frame_err;
    end

    // Reference model
    logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                8'h35, 8'h1A};
    bit         m_brk = 0, m_ext = 0, m_shift = 0;
    int         exp_q[$];
    int         exp_err = 0;

    function automatic int m_map(input logic [7:0] sc, input bit ext, input bit shf);
        if (ext) return (sc == 8'h75) ? 67 : (sc == 8'h72) ? 68 : 0;
        for (int i = 0; i < 26; i++)
            if (letters[i] == sc) return shf ? i + 27 : i + 1;
        case (sc)
            8'h25: return shf ? 53 : 0;
            8'h46: return shf ? 54 : 0;
            8'h45: return shf ? 55 : 0;
            8'h55: return shf ? 0 : 56;
            8'h5D: return 58;
            8'h29: return 59;
            8'h49: return shf ? 0 : 60;
            8'h66: return 65;
            8'h5A: return 66;
            default: return 0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int c;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
            else if (!m_brk) begin
                c = m_map(b, m_ext, m_shift);
                if (c != 0) exp_q.push_back(c);
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic model_err();
        m_brk = 0;
        m_ext = 0;
        exp_err++;
    endtask

    // Pin drivers (changes made on negedge, away from the sampling edge)
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_t = $time;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11);
        repeat (GAP) @(negedge clk);
        if (bad_par) model_err();
        else model_byte(b);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        chk({tag, "/ncodes"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "/code"}, 32'(got_q.pop_front()), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "/shift"}, 32'(shift_state), 32'(m_shift));
        chk({tag, "/errs"}, err_seen, exp_err);
    endtask

    initial begin
        #950us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool[24] = '{8'h1C, 8'h32, 8'h1A, 8'h24, 8'h15, 8'h12, 8'h59, 8'hF0,
                                 8'hF0, 8'hE0, 8'hE0, 8'h25, 8'h46, 8'h45, 8'h55, 8'h5D,
                                 8'h29, 8'h49, 8'h66, 8'h5A, 8'h75, 8'h72, 8'h2B, 8'h00};
        logic [7:0] b;

        // Reset values
        repeat (4) @(negedge clk);
        chk("rst/ch_code", 32'(ch_code), 0);
        chk("rst/frame_err", 32'(frame_err), 0);
        chk("rst/shift", 32'(shift_state), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset");

        // Single key, latency from raw stop edge, break suppression
        send_frame(8'h1C, 0);
        chk("latency_ns", 32'(code_t - stop_t), 40);
        check("a");
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("a_break");

        // Typematic repeat emits again
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        check("repeat");

        // Shift handling
        send_frame(8'h12, 0);
        check("shift_dn");
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("shift_A");
        send_frame(8'hF0, 0);
        send_frame(8'h12, 0);
        check("shift_up");
        send_frame(8'h1C, 0);
        check("after_shift");

        // Extended arrows
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'h72, 0);
        send_frame(8'h75, 0);
        check("arrows");

        // Parity error then good frame
        send_frame(8'h1C, 1);
        check("bad_parity");
        send_frame(8'h32, 0);
        check("after_parity");

        // Stop-bit error clears a pending break
        send_frame(8'hF0, 0);
        send_bits({1'b0, ~(^8'h24), 8'h24, 1'b0}, 11);
        repeat (GAP) @(negedge clk);
        model_err();
        send_frame(8'h24, 0);
        check("bad_stop");

        // Partial frame timeout
        send_bits({1'b1, ~(^8'h5A), 8'h5A, 1'b0}, 5);
        repeat (TMO + 40) @(negedge clk);
        model_err();
        check("timeout");
        send_frame(8'h5A, 0);
        check("after_timeout");

        // Reset mid-frame discards state
        send_frame(8'h12, 0);
        send_frame(8'hF0, 0);
        send_bits({1'b1, ~(^8'h29), 8'h29, 1'b0}, 6);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_brk = 0; m_ext = 0; m_shift = 0;
        repeat (GAP) @(negedge clk);
        check("mid_reset");
        send_frame(8'h29, 0);
        check("space");

        // Random key streams
        for (int k = 0; k < 60; k++) begin
            b = pool[$urandom_range(0, 23)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 11) == 0));
            check("rand");
        end

        chk("pulse_width", dbl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
